// File: rtl/event_counter_pkg.sv
// event_counter_pkg: shared types and constants for the event_counter slice.
//   - deb_state_e : key debounce FSM states
//   - SEG_LUT     : active-low seven-segment patterns {g,f,e,d,c,b,a} for 0-F
//   - SEG_BLANK / SEG_ZERO : all-off and "0" patterns
//   - cnt_width() : count width derived from the number of hex digits
//   - seg_decode(): nibble to segment pattern
package event_counter_pkg;

    typedef enum logic [1:0] {
        StReleased,
        StWaitLow,
        StPressed,
        StWaitHigh
    } deb_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic int unsigned cnt_width(input int unsigned digits);
        return 4 * digits;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        return SEG_LUT[nib];
    endfunction

endpackage

// File: rtl/event_counter_key_debounce.sv
// key_debounce: turns a synchronised active-low key level into a one-cycle press pulse.
// Build option EVENT_COUNTER_DEBOUNCE_EN:
//   defined   - four-state FSM; an edge is accepted only after the new level has been
//               stable for DEBOUNCE_CYCLES cycles. Resets into StWaitHigh so a key held
//               through reset must be released before it can count.
//   undefined - plain falling-edge detector; every bounce produces a pulse.
// Ports:
//   clk100_i - system clock
//   rst_i    - synchronous active-high reset
//   key_n_i  - synchronised key level, low = pressed
//   press_o  - registered one-cycle press pulse
module key_debounce
    import event_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk100_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic press_o
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
        $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    logic press_q, press_d;

`ifdef EVENT_COUNTER_DEBOUNCE_EN

    localparam int unsigned TimerW = $clog2(DEBOUNCE_CYCLES);
    // Timer counts down to zero, so a load of N-1 gives N cycles in a wait state.
    localparam logic [TimerW-1:0] TimerLoad = TimerW'(DEBOUNCE_CYCLES - 1);

    deb_state_e        state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        press_d = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (!key_n_i) begin
                    state_d = StWaitLow;
                    timer_d = TimerLoad;
                end
            end
            StWaitLow: begin
                if (key_n_i) begin
                    state_d = StReleased;
                end else if (timer_q == '0) begin
                    state_d = StPressed;
                    press_d = 1'b1;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StPressed: begin
                if (key_n_i) begin
                    state_d = StWaitHigh;
                    timer_d = TimerLoad;
                end
            end
            StWaitHigh: begin
                if (!key_n_i) begin
                    state_d = StPressed;
                end else if (timer_q == '0) begin
                    state_d = StReleased;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            default: begin
                state_d = StWaitHigh;
                timer_d = TimerLoad;
            end
        endcase
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            state_q <= StWaitHigh;
            timer_q <= TimerLoad;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            press_q <= press_d;
        end
    end

`else

    // Previous level resets high, matching the released synchroniser state.
    logic prev_q;

    always_comb begin
        press_d = prev_q & ~key_n_i;
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            prev_q  <= 1'b1;
            press_q <= 1'b0;
        end else begin
            prev_q  <= key_n_i;
            press_q <= press_d;
        end
    end

`endif

    assign press_o = press_q;

endmodule

// File: rtl/event_counter.sv
// event_counter: board-level press counter.
// Counts debounced step-key presses up or down (direction key level), clears on the
// clear key, captures the switch bank onto the LEDs on each counted step and shows the
// count in hex on DIGITS seven-segment displays.
// Build option EVENT_COUNTER_DEBOUNCE_EN enables the debounce FSM in key_debounce;
// without it each synchronised falling edge counts.
// Ports:
//   clk100_i - system clock (only clock)
//   rst_i    - synchronous active-high reset
//   sw_i     - switch bank, captured on a counted step
//   key_i    - active-low asynchronous keys: [2] step, [1] clear, [0] direction (1 = up)
//   ledr_o   - last captured switch value
//   hex_o    - active-low segments, digit i at [7*i+6:7*i], digit 0 = least significant
//   cnt_o    - current count
//   wrap_o   - one-cycle pulse when a step wraps the count
module event_counter
    import event_counter_pkg::*;
#(
    parameter int unsigned SW_W            = 10,
    parameter int unsigned DIGITS          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    localparam int unsigned CNT_W          = cnt_width(DIGITS)
) (
    input  logic                  clk100_i,
    input  logic                  rst_i,
    input  logic [SW_W-1:0]       sw_i,
    input  logic [2:0]            key_i,
    output logic [SW_W-1:0]       ledr_o,
    output logic [7*DIGITS-1:0]   hex_o,
    output logic [CNT_W-1:0]      cnt_o,
    output logic                  wrap_o
);

    // Two-stage synchroniser for all keys; resets to the released (high) level.
    logic [2:0] key_meta_q, key_meta_d;
    logic [2:0] key_sync_q, key_sync_d;

    always_comb begin
        key_meta_d = key_i;
        key_sync_d = key_meta_q;
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            key_meta_q <= 3'b111;
            key_sync_q <= 3'b111;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
        end
    end

    logic step_press, clr_press;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_debounce (
        .clk100_i (clk100_i),
        .rst_i    (rst_i),
        .key_n_i  (key_sync_q[2]),
        .press_o  (step_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr_debounce (
        .clk100_i (clk100_i),
        .rst_i    (rst_i),
        .key_n_i  (key_sync_q[1]),
        .press_o  (clr_press)
    );

    // Direction is a plain level, read on the cycle the step pulse arrives.
    logic dir_up;
    assign dir_up = key_sync_q[0];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW_W-1:0]  ledr_q, ledr_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        cnt_d  = cnt_q;
        ledr_d = ledr_q;
        wrap_d = 1'b0;
        if (clr_press) begin
            // Clear has priority over a simultaneous step: no capture, no wrap.
            cnt_d = '0;
        end else if (step_press) begin
            ledr_d = sw_i;
            if (dir_up) begin
                cnt_d  = cnt_q + CNT_W'(1);
                wrap_d = &cnt_q;
            end else begin
                cnt_d  = cnt_q - CNT_W'(1);
                wrap_d = ~|cnt_q;
            end
        end
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            ledr_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ledr_q <= ledr_d;
            wrap_q <= wrap_d;
        end
    end

    // Registered hex display, one cycle behind the count.
    logic [7*DIGITS-1:0] hex_q, hex_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_hex
        assign hex_d[7*g +: 7] = seg_decode(cnt_q[4*g +: 4]);
    end

    always_ff @(posedge clk100_i) begin
        if (rst_i) begin
            hex_q <= {DIGITS{SEG_ZERO}};
        end else begin
            hex_q <= hex_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign ledr_o = ledr_q;
    assign wrap_o = wrap_q;
    assign hex_o  = hex_q;

endmodule

// File: tb/tb_event_counter.sv
// Directed bench for event_counter at SW_W=10, DIGITS=3, DEBOUNCE_CYCLES=4.
// Expectations adapt to whether EVENT_COUNTER_DEBOUNCE_EN is defined.
module tb_event_counter;

    localparam int unsigned SW_W   = 10;
    localparam int unsigned DIGITS = 3;
    localparam int unsigned DEB    = 4;
    localparam int unsigned CNT_W  = 12;

`ifdef EVENT_COUNTER_DEBOUNCE_EN
    localparam bit DebOn = 1'b1;
`else
    localparam bit DebOn = 1'b0;
`endif
    // Edge index (0 = first edge sampling a low key) after which the press pulse is high.
    localparam int unsigned LAT = DebOn ? 2 + DEB : 2;

    logic                clk = 1'b0;
    logic                rst_i;
    logic [SW_W-1:0]     sw_i;
    logic [2:0]          key_i;
    logic [SW_W-1:0]     ledr_o;
    logic [7*DIGITS-1:0] hex_o;
    logic [CNT_W-1:0]    cnt_o;
    logic                wrap_o;

    event_counter #(
        .SW_W            (SW_W),
        .DIGITS          (DIGITS),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk100_i (clk),
        .rst_i    (rst_i),
        .sw_i     (sw_i),
        .key_i    (key_i),
        .ledr_o   (ledr_o),
        .hex_o    (hex_o),
        .cnt_o    (cnt_o),
        .wrap_o   (wrap_o)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [20:0] hex_of(input logic [11:0] c);
        return {seg7(c[11:8]), seg7(c[7:4]), seg7(c[3:0])};
    endfunction

    typedef struct {
        logic        step;
        logic        clr;
        logic        dir;
        logic [9:0]  sw;
        logic [11:0] exp_cnt;
        logic [9:0]  exp_ledr;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs [15];

    // Press the selected keys, sample around the expected update edge, then release.
    task automatic press(input logic step, input logic clr, input logic dir,
                         input logic [9:0] sw,
                         output logic [11:0] pre_cnt, output logic pre_wrap,
                         output logic [11:0] cnt_at, output logic wrap_at,
                         output logic wrap_after, output logic [20:0] hex_at,
                         output logic [9:0] ledr_at);
        key_i = {~step, ~clr, dir};
        sw_i  = sw;
        repeat (LAT + 1) tick();
        pre_cnt  = cnt_o;
        pre_wrap = wrap_o;
        tick();
        cnt_at  = cnt_o;
        wrap_at = wrap_o;
        ledr_at = ledr_o;
        tick();
        wrap_after = wrap_o;
        hex_at     = hex_o;
        key_i = {2'b11, dir};
        repeat (DEB + 6) tick();
    endtask

    logic [11:0] pre_cnt, cnt_at, exp_prev, base;
    logic        pre_wrap, wrap_at, wrap_after;
    logic [20:0] hex_at;
    logic [9:0]  ledr_at;
    logic [13:0] bounce_pat;
    logic [11:0] exp_c;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 10'h2A5, 12'h001, 10'h2A5, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 10'h2A5, 12'h002, 10'h2A5, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 10'h2A5, 12'h003, 10'h2A5, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 10'h3FF, 12'h000, 10'h2A5, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 10'h155, 12'hFFF, 10'h155, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 10'h0AA, 12'h000, 10'h0AA, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 10'h001, 12'h001, 10'h001, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 10'h002, 12'h002, 10'h002, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 10'h003, 12'h003, 10'h003, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 10'h004, 12'h004, 10'h004, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 10'h005, 12'h005, 10'h005, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 10'h3C3, 12'h000, 10'h005, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 10'h000, 12'hFFF, 10'h000, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 10'h1E7, 12'hFFE, 10'h1E7, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 10'h3FF, 12'hFFF, 10'h3FF, 1'b0};

        // Reset with keys released.
        rst_i = 1'b1;
        key_i = 3'b111;
        sw_i  = '0;
        repeat (3) tick();
        check("reset cnt", 32'(cnt_o), 32'h0);
        check("reset ledr", 32'(ledr_o), 32'h0);
        check("reset wrap", 32'(wrap_o), 32'h0);
        check("reset hex", 32'(hex_o), 32'(hex_of(12'h000)));
        rst_i = 1'b0;
        repeat (DEB + 6) tick();

        // Table of single presses.
        exp_prev = 12'h000;
        for (int i = 0; i < 15; i++) begin
            press(vecs[i].step, vecs[i].clr, vecs[i].dir, vecs[i].sw,
                  pre_cnt, pre_wrap, cnt_at, wrap_at, wrap_after, hex_at, ledr_at);
            check($sformatf("v%0d cnt before update", i), 32'(pre_cnt), 32'(exp_prev));
            check($sformatf("v%0d wrap before update", i), 32'(pre_wrap), 32'h0);
            check($sformatf("v%0d cnt", i), 32'(cnt_at), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d wrap", i), 32'(wrap_at), 32'(vecs[i].exp_wrap));
            check($sformatf("v%0d wrap one cycle", i), 32'(wrap_after), 32'h0);
            check($sformatf("v%0d ledr", i), 32'(ledr_at), 32'(vecs[i].exp_ledr));
            check($sformatf("v%0d hex", i), 32'(hex_at), 32'(hex_of(vecs[i].exp_cnt)));
            check($sformatf("v%0d cnt held", i), 32'(cnt_o), 32'(vecs[i].exp_cnt));
            exp_prev = vecs[i].exp_cnt;
        end

        // Bouncing step: low 2, high 1, then low held. Bit k is the level for edge k.
        base       = cnt_o;
        bounce_pat = 14'b00_0000_0000_0100;
        sw_i       = 10'h2DB;
        for (int k = 0; k < 14; k++) begin
            key_i = {bounce_pat[k], 2'b11};
            tick();
            if (DebOn) exp_c = base + ((k >= 10) ? 12'd1 : 12'd0);
            else       exp_c = base + ((k >= 3) ? 12'd1 : 12'd0) + ((k >= 6) ? 12'd1 : 12'd0);
            check($sformatf("bounce cnt edge %0d", k), 32'(cnt_o), 32'(exp_c));
        end
        check("bounce ledr", 32'(ledr_o), 32'h2DB);
        key_i = 3'b111;
        repeat (DEB + 6) tick();

        // Step held low across a reset pulse; the pending press must be abandoned.
        sw_i  = 10'h0F0;
        key_i = 3'b011;
        repeat (3) tick();
        rst_i = 1'b1;
        tick();
        check("hold rst cnt", 32'(cnt_o), 32'h0);
        check("hold rst ledr", 32'(ledr_o), 32'h0);
        check("hold rst wrap", 32'(wrap_o), 32'h0);
        repeat (2) tick();
        check("hold rst hex", 32'(hex_o), 32'(hex_of(12'h000)));
        rst_i = 1'b0;
        repeat (20) tick();
        // Only the bare edge detector sees the synchroniser fall after reset.
        check("hold after rst cnt", 32'(cnt_o), DebOn ? 32'h0 : 32'h1);
        check("hold after rst ledr", 32'(ledr_o), DebOn ? 32'h0 : 32'h0F0);
        check("hold after rst hex", 32'(hex_o),
              32'(hex_of(DebOn ? 12'h000 : 12'h001)));
        key_i = 3'b111;
        repeat (DEB + 6) tick();
        press(1'b1, 1'b0, 1'b1, 10'h111,
              pre_cnt, pre_wrap, cnt_at, wrap_at, wrap_after, hex_at, ledr_at);
        check("re-press cnt", 32'(cnt_at), DebOn ? 32'h1 : 32'h2);
        check("re-press ledr", 32'(ledr_at), 32'h111);
        check("re-press wrap", 32'(wrap_at), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
